// File: rtl/prbs7_chk_if.sv
// Bundles the PRBS7 checker's data input, clear and status outputs.
// Latency: none, wires only.
// Backpressure: none; the checker always accepts data when data_vld is high.
// Ports: data/data_vld/clr (master -> checker); locked, err_word,
//        word_err_cnt and, with PRBS7_CHK_BITCNT_EN defined, bit_err_cnt
//        (checker -> master).
interface prbs7_chk_if #(
  parameter int WIDTH = 24
);
  logic [WIDTH-1:0] data;
  logic             data_vld;
  logic             clr;
  logic             locked;
  logic             err_word;
  logic [15:0]      word_err_cnt;
`ifdef PRBS7_CHK_BITCNT_EN
  logic [31:0]      bit_err_cnt;

  modport master (output data, data_vld, clr,
                  input  locked, err_word, word_err_cnt, bit_err_cnt);
  modport slave  (input  data, data_vld, clr,
                  output locked, err_word, word_err_cnt, bit_err_cnt);
`else
  modport master (output data, data_vld, clr,
                  input  locked, err_word, word_err_cnt);
  modport slave  (input  data, data_vld, clr,
                  output locked, err_word, word_err_cnt);
`endif
endinterface

// File: rtl/prbs7_chk.sv
// Parallel PRBS7 checker: self-synchronises to a received word stream,
// then flags and counts errored words (and errored bits when
// PRBS7_CHK_BITCNT_EN is defined).
// Latency: locked/err_word/counters update one cycle after the valid word.
// Backpressure: none; every word with data_vld=1 is consumed and words
// with data_vld=0 leave all state untouched.
// Ports: clk, rst_n (async, active low); bus (prbs7_chk_if.slave).
module prbs7_chk #(
  parameter int WIDTH      = 24,
  parameter int TAP1       = 6,
  parameter int TAP2       = 5,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  prbs7_chk_if.slave bus
);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state;
  logic             locked_q;
  logic             err_word_q;
  logic [15:0]      word_err_cnt;
  logic [3:0]       match_cnt;
  logic [3:0]       bad_cnt;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] exp_w;

  // Run the LFSR WIDTH bit-times forward from the word w.
  function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] s;
    s = w;
    for (int i = 0; i < WIDTH; i++) s = {s[WIDTH-2:0], s[TAP1] ^ s[TAP2]};
    return s;
  endfunction

  logic [WIDTH-1:0] prev_nxt, exp_nxt, data_nxt;
  logic             seed_zero, seed_match, word_miss, err_inc;

  assign prev_nxt   = nxt(prev);
  assign exp_nxt    = nxt(exp_w);
  assign data_nxt   = nxt(bus.data);
  // A zero LFSR state would reproduce zeros forever, so never seed from it.
  assign seed_zero  = (bus.data[6:0] == 7'd0);
  assign seed_match = (bus.data == prev_nxt);
  assign word_miss  = (bus.data != exp_w);
  assign err_inc    = bus.data_vld && (state == LOCKED) && word_miss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEARCH;
      locked_q   <= 1'b0;
      err_word_q <= 1'b0;
      match_cnt  <= '0;
      bad_cnt    <= '0;
      prev       <= '0;
      exp_w      <= '0;
    end else begin
      err_word_q <= 1'b0;
      if (bus.data_vld) begin
        case (state)
          SEARCH: begin
            if (seed_zero) begin
              match_cnt <= '0;
            end else begin
              prev <= bus.data;
              if (!seed_match) begin
                match_cnt <= '0;
              end else if (match_cnt == 4'(LOCK_CNT - 1)) begin
                state     <= LOCKED;
                locked_q  <= 1'b1;
                exp_w     <= data_nxt;
                bad_cnt   <= '0;
                match_cnt <= '0;
              end else begin
                match_cnt <= match_cnt + 4'd1;
              end
            end
          end
          LOCKED: begin
            // Free-running reference: a bad word never corrupts exp_w.
            exp_w <= exp_nxt;
            if (word_miss) begin
              err_word_q <= 1'b1;
              if (bad_cnt == 4'(UNLOCK_CNT - 1)) begin
                state     <= SEARCH;
                locked_q  <= 1'b0;
                match_cnt <= '0;
                bad_cnt   <= '0;
                prev      <= bus.data;
              end else begin
                bad_cnt <= bad_cnt + 4'd1;
              end
            end else begin
              bad_cnt <= '0;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      word_err_cnt <= '0;
    else if (bus.clr)
      word_err_cnt <= '0;
    else if (err_inc && (word_err_cnt != 16'hFFFF))
      word_err_cnt <= word_err_cnt + 16'd1;
  end

  assign bus.locked       = locked_q;
  assign bus.err_word     = err_word_q;
  assign bus.word_err_cnt = word_err_cnt;

`ifdef PRBS7_CHK_BITCNT_EN
  localparam int POPW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] diff;
  logic [POPW-1:0]  pop;
  logic [32:0]      bit_sum;
  logic [31:0]      bit_err_cnt;

  assign diff = bus.data ^ exp_w;

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + POPW'(diff[i]);
  end

  // One extra bit catches the carry out so the count sticks at all-ones.
  assign bit_sum = {1'b0, bit_err_cnt} + 33'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bit_err_cnt <= '0;
    else if (bus.clr)
      bit_err_cnt <= '0;
    else if (err_inc)
      bit_err_cnt <= bit_sum[32] ? 32'hFFFF_FFFF : bit_sum[31:0];
  end

  assign bus.bit_err_cnt = bit_err_cnt;
`endif

endmodule

// File: tb/tb_prbs7_chk.sv
module tb_prbs7_chk;
  localparam int W  = 24;
  localparam int LK = 4;
  localparam int UL = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prbs7_chk_if #(.WIDTH(W)) b1 ();
  prbs7_chk_if #(.WIDTH(W)) b2 ();

  prbs7_chk #(.WIDTH(W), .TAP1(6), .TAP2(5), .LOCK_CNT(LK), .UNLOCK_CNT(UL))
    u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  prbs7_chk #(.WIDTH(W), .TAP1(6), .TAP2(5), .LOCK_CNT(LK), .UNLOCK_CNT(15))
    u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  int checks = 0;
  int errors = 0;

  // Reference model state for u1.
  bit           m_locked;
  bit           m_err;
  int           m_match, m_bad;
  int           m_werr;
  longint       m_berr;
  logic [W-1:0] m_prev, m_exp;
  logic [W-1:0] gen;

  function automatic logic [W-1:0] nxt(input logic [W-1:0] w);
    logic [W-1:0] s;
    s = w;
    for (int i = 0; i < W; i++) s = {s[W-2:0], s[6] ^ s[5]};
    return s;
  endfunction

  function automatic int popc(input logic [W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < W; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_err = 0; m_match = 0; m_bad = 0;
    m_werr = 0; m_berr = 0; m_prev = '0; m_exp = '0;
  endtask

  task automatic model(input logic [W-1:0] d, input bit v, input bit c);
    m_err = 0;
    if (v) begin
      if (!m_locked) begin
        if (d[6:0] == 7'd0) begin
          m_match = 0;
        end else begin
          m_match = (d == nxt(m_prev)) ? m_match + 1 : 0;
          m_prev  = d;
          if (m_match == LK) begin
            m_locked = 1; m_exp = nxt(d); m_bad = 0;
          end
        end
      end else begin
        if (d != m_exp) begin
          m_err = 1;
          if (m_werr < 65535) m_werr++;
          m_berr += longint'(popc(d ^ m_exp));
          if (m_berr > 64'hFFFF_FFFF) m_berr = 64'hFFFF_FFFF;
          m_bad++;
          if (m_bad == UL) begin
            m_locked = 0; m_match = 0; m_prev = d;
          end
        end else begin
          m_bad = 0;
        end
        m_exp = nxt(m_exp);
      end
    end
    if (c) begin m_werr = 0; m_berr = 0; end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/locked"}, 64'(b1.locked), 64'(m_locked));
    chk({tag, "/err_word"}, 64'(b1.err_word), 64'(m_err));
    chk({tag, "/word_err_cnt"}, 64'(b1.word_err_cnt), 64'(m_werr));
`ifdef PRBS7_CHK_BITCNT_EN
    chk({tag, "/bit_err_cnt"}, 64'(b1.bit_err_cnt), 64'(m_berr));
`endif
  endtask

  task automatic step(input logic [W-1:0] d, input bit v, input bit c);
    b1.data = d; b1.data_vld = v; b1.clr = c;
    @(posedge clk);
    model(d, v, c);
    #1;
  endtask

  task automatic step2(input logic [W-1:0] d, input bit v);
    b2.data = d; b2.data_vld = v; b2.clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rmask();
    logic [W-1:0] m;
    m = W'($urandom) | W'(1);
    return m;
  endfunction

  initial begin
    int nv;
    int p;
    int nerr;
    logic [W-1:0] m;

    b1.data = '0; b1.data_vld = 1'b0; b1.clr = 1'b0;
    b2.data = '0; b2.data_vld = 1'b0; b2.clr = 1'b0;
    model_reset();
    #23;
    check_all("reset");
    chk("reset/u2_cnt", 64'(b2.word_err_cnt), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean stream seeded with 1: lock on the LK+1-th valid word.
    gen = W'(1);
    for (int k = 0; k <= LK; k++) begin
      step(gen, 1, 0); gen = nxt(gen);
      chk("seed1/lock_time", 64'(b1.locked), 64'(k == LK));
      check_all("seed1");
    end
    for (int k = 0; k < 20; k++) begin
      step(gen, 1, 0); gen = nxt(gen);
      check_all("clean_locked");
    end

    // Three flipped bits in one word.
    p = $urandom_range(7);
    m = '0; m[p] = 1'b1; m[p+8] = 1'b1; m[p+16] = 1'b1;
    step(gen ^ m, 1, 0); gen = nxt(gen);
    chk("flip3/err_word", 64'(b1.err_word), 64'd1);
    chk("flip3/word_err_cnt", 64'(b1.word_err_cnt), 64'd1);
`ifdef PRBS7_CHK_BITCNT_EN
    chk("flip3/bit_err_cnt", 64'(b1.bit_err_cnt), 64'd3);
`endif
    check_all("flip3");
    step(gen, 1, 0); gen = nxt(gen);
    chk("flip3/pulse_once", 64'(b1.err_word), 64'd0);
    chk("flip3/still_locked", 64'(b1.locked), 64'd1);

    // Clear, then four consecutive bad words drop lock.
    step(gen, 1, 1); gen = nxt(gen);
    check_all("clr_clean");
    for (int k = 0; k < 4; k++) begin
      step(gen ^ rmask(), 1, 0); gen = nxt(gen);
      chk("burst4/locked", 64'(b1.locked), 64'(k != 3));
      check_all("burst4");
    end
    chk("burst4/word_err_cnt", 64'(b1.word_err_cnt), 64'd4);
    for (int k = 0; k <= LK; k++) begin
      step(gen, 1, 0); gen = nxt(gen);
      chk("relock/lock_time", 64'(b1.locked), 64'(k == LK));
      check_all("relock");
    end

    // Reset pulse mid-lock clears outputs without a clock edge.
    rst_n = 1'b0; #1;
    model_reset();
    check_all("rst_mid");
    #2 rst_n = 1'b1;

    // All-zero input never locks and never counts.
    for (int k = 0; k < 100; k++) begin
      step('0, 1, 0);
      check_all("zeros");
    end
    chk("zeros/locked", 64'(b1.locked), 64'd0);

    // Gapped clean stream from a random seed.
    gen = W'($urandom) | W'(1);
    nv = 0;
    for (int k = 0; k < 200 && nv < LK + 1; k++) begin
      if ($urandom_range(1) == 1) begin
        step(gen, 1, 0); gen = nxt(gen); nv++;
        chk("gapped/lock_time", 64'(b1.locked), 64'(nv == LK + 1));
      end else begin
        step(W'($urandom), 0, 0);
      end
      check_all("gapped");
    end
    chk("gapped/valid_words", 64'(nv), 64'(LK + 1));
    chk("gapped/no_errors", 64'(b1.word_err_cnt), 64'd0);

    // Clear wins over a simultaneous error.
    step(gen ^ rmask(), 1, 1); gen = nxt(gen);
    chk("clr_err/word_err_cnt", 64'(b1.word_err_cnt), 64'd0);
    chk("clr_err/err_word", 64'(b1.err_word), 64'd1);
    check_all("clr_err");

    // Random mix of gaps, corruption, zero words and clears.
    for (int k = 0; k < 400; k++) begin
      bit v, c;
      logic [W-1:0] d;
      v = ($urandom_range(3) != 0);
      c = ($urandom_range(31) == 0);
      d = gen;
      if ($urandom_range(7) == 0) d = gen ^ rmask();
      if ($urandom_range(63) == 0) d = '0;
      step(d, v, c);
      if (v) gen = nxt(gen);
      check_all("random");
    end

    // u2 (UNLOCK_CNT=15): 14 bad + 1 good keeps lock while the count saturates.
    gen = W'(1);
    for (int k = 0; k <= LK; k++) begin
      step2(gen, 1); gen = nxt(gen);
    end
    chk("sat/locked_start", 64'(b2.locked), 64'd1);
    nerr = 0;
    while (nerr < 65535 + 20) begin
      for (int k = 0; k < 14; k++) begin
        step2(gen ^ rmask(), 1); gen = nxt(gen); nerr++;
      end
      step2(gen, 1); gen = nxt(gen);
      chk("sat/word_err_cnt", 64'(b2.word_err_cnt), 64'((nerr > 65535) ? 65535 : nerr));
      chk("sat/locked", 64'(b2.locked), 64'd1);
    end
    chk("sat/final", 64'(b2.word_err_cnt), 64'hFFFF);

    // Reset pulse while u2 is locked and saturated.
    rst_n = 1'b0; #1;
    model_reset();
    chk("sat_rst/locked", 64'(b2.locked), 64'd0);
    chk("sat_rst/err_word", 64'(b2.err_word), 64'd0);
    chk("sat_rst/word_err_cnt", 64'(b2.word_err_cnt), 64'd0);
    check_all("sat_rst");
    #2 rst_n = 1'b1;
    b2.data_vld = 1'b0;

    // Relock after reset takes LK+1 valid words.
    for (int k = 0; k <= LK; k++) begin
      step(gen, 1, 0); gen = nxt(gen);
      chk("post_rst/lock_time", 64'(b1.locked), 64'(k == LK));
      check_all("post_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prbs7_chk.md
PRBS7_CHK -- requirements
Module: prbs7_chk

Interface
REQ-001 Parameter WIDTH, default 24, SHALL set the parallel word width in bits.
REQ-002 Parameter TAP1, default 6, SHALL set the first feedback tap index.
REQ-003 Parameter TAP2, default 5, SHALL set the second feedback tap index.
REQ-004 Parameter LOCK_CNT, default 4, SHALL set the number of consecutive matching words needed to lock (range 1..15).
REQ-005 Parameter UNLOCK_CNT, default 4, SHALL set the number of consecutive errored words that drops lock (range 1..15).
REQ-006 clk  input  1  clock; all state SHALL change on posedge clk.
REQ-007 rst_n  input  1  reset; asynchronous, active-low.
REQ-008 data  input  WIDTH  received PRBS7 word, sampled when data_vld=1.
REQ-009 data_vld  input  1  data qualifier; words with data_vld=0 SHALL be ignored and SHALL not advance any state.
REQ-010 clr  input  1  synchronous clear of all error counters.
REQ-011 locked  output  1  registered; 1 while in LOCKED state.
REQ-012 err_word  output  1  registered one-cycle pulse; the previous valid word mismatched while LOCKED.
REQ-013 word_err_cnt  output  16  saturating count of errored words while LOCKED.

Function
REQ-014 Next-word function N(w) SHALL be: s=w; repeat WIDTH times s={s[WIDTH-2:0], s[TAP1]^s[TAP2]}; N(w)=s.
REQ-015 States SHALL be SEARCH and LOCKED; reset state SHALL be SEARCH.
REQ-016 SEARCH: on each valid word, compare with exp=N(previous valid word); on match, increment match_cnt; on mismatch, match_cnt=0; always set prev=data.
REQ-017 SEARCH: a valid word with bits [6:0]=0 SHALL set match_cnt=0 and SHALL NOT be used as seed (prevents all-zero lockup).
REQ-018 SEARCH->LOCKED SHALL occur on the valid word that brings match_cnt to LOCK_CNT; locked SHALL be 1 in the following cycle.
REQ-019 LOCKED: expected word SHALL advance as exp<=N(exp) per valid word, independent of received data (errors do not propagate).
REQ-020 LOCKED: a mismatching valid word SHALL pulse err_word on the next cycle, increment word_err_cnt, increment bad_cnt; a matching word SHALL clear bad_cnt.
REQ-021 LOCKED->SEARCH SHALL occur when bad_cnt reaches UNLOCK_CNT; match_cnt=0, prev=that word, locked=0 on the next cycle.
REQ-022 Counters SHALL saturate at all-ones and never wrap.
REQ-023 clr=1 SHALL zero all error counters that cycle with priority over a simultaneous increment; clr SHALL not affect state, lock, or err_word.
REQ-024 No errors SHALL be counted or flagged while in SEARCH.

Reset
REQ-025 rst_n=0 SHALL asynchronously force: state=SEARCH, locked=0, err_word=0, word_err_cnt=0, bit_err_cnt=0 (if present), match_cnt=0, bad_cnt=0, prev=0, exp=0.
REQ-026 Reset asserted mid-lock SHALL discard lock; after release, relock SHALL take LOCK_CNT+1 valid words.

Configuration
REQ-027 Macro PRBS7_CHK_BITCNT_EN defined: output bit_err_cnt[31:0] SHALL exist and add popcount(data^exp) per valid LOCKED word, saturating at 2^32-1, cleared by clr and reset.
REQ-028 Macro PRBS7_CHK_BITCNT_EN undefined: port bit_err_cnt and its popcount logic SHALL be absent; all other behaviour unchanged.

Verification
REQ-029 Generator seeded 1, data_vld=1 every cycle -> locked=1 exactly LOCK_CNT+1 cycles after first valid word (5 with defaults), counters stay 0.
REQ-030 Locked stream, flip 3 bits of one word -> err_word pulses once, word_err_cnt=1, bit_err_cnt=3 (macro on), locked stays 1.
REQ-031 Locked stream, corrupt 4 consecutive words -> locked falls after 4th, word_err_cnt=4; clean stream resumes -> relock after 5 words.
REQ-032 All-zero input for 100 words -> locked stays 0, no counter change.
REQ-033 data_vld toggled 1/0 pseudo-randomly on clean stream -> lock achieved after 5 valid words, zero errors; clr asserted with error same cycle -> word_err_cnt=0.
REQ-034 Force word_err_cnt near 16'hFFFF via continuous errors (UNLOCK_CNT=15 override) -> saturates at 16'hFFFF; rst_n pulse mid-lock -> all outputs 0 immediately.
